nicnac16_timing_gen: RTL and testbench
======================================

Name: nicnac16_timing_gen

Overview:
Major/minor cycle sequencer for the dunc16 datapath. It generates the FETCH/EXECUTE major-state levels and the one-hot T0..T3 minor-state strobes that dunc16 consumes. It holds the memory WRITE flip-flop driven by dunc16's SETWRITE/CLRWRITE, and adds run/stop/single-step control, memory wait states and a bus-timeout trap.

Parameters:
CNT_W, 16, width of the retired-instruction counter
MAX_WAIT, 15, maximum consecutive T1 wait cycles before bus timeout (1..255)

Ports:
CLK  input  1  system clock, rising-edge active
RESET  input  1  asynchronous, active-low reset
START  input  1  begin free-running execution (sampled in IDLE)
STEP  input  1  execute exactly one instruction (sampled in IDLE)
STOP  input  1  request halt at the next instruction boundary
I_HLT  input  1  decoded halt instruction from dunc16
MEM_READY  input  1  memory ready; low stretches T1
SETWRITE  input  1  set the WRITE flip-flop (from dunc16)
CLRWRITE  input  1  clear the WRITE flip-flop (from dunc16)
FETCH  output  1  fetch major cycle
EXECUTE  output  1  execute major cycle
T0, T1, T2, T3  output  1 each  one-hot minor-cycle strobes
WRITE  output  1  memory write enable
RUNNING  output  1  sequencer active
BUS_ERR  output  1  sticky timeout flag
INSTR_COUNT  output  CNT_W  retired-instruction count

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, FETCH=1, EXECUTE=0, T0..T3=0, WRITE=0, RUNNING=0, BUS_ERR=0, INSTR_COUNT=0, stop_pend=0, step_mode=0, wait_cnt=0.
- States: IDLE and RUN. In RUN, exactly one of T0..T3 is high. FETCH and EXECUTE are always complementary.
- IDLE to RUN:
  - START=1 on a clock edge in IDLE: next cycle FETCH=1, T0=1, RUNNING=1, step_mode=0, BUS_ERR cleared.
  - STEP=1 (START=0) on a clock edge in IDLE: same transition, with step_mode=1.
  - START and STEP together: START wins.
  - START and STEP are ignored while in RUN.
- Minor sequence:
  - T0 to T1 to T2 to T3, one cycle each.
  - T1 advances to T2 only on a cycle with MEM_READY=1. Each T1 cycle with MEM_READY=0 increments wait_cnt. wait_cnt clears on leaving T1.
  - Minimum instruction is 8 cycles (4 FETCH + 4 EXECUTE).
- Major transitions:
  - FETCH T3 to EXECUTE T0.
  - EXECUTE T3 to FETCH T0 unless halting.
  - On every EXECUTE T3 exit, INSTR_COUNT increments, wrapping modulo 2^CNT_W.
- Halt:
  - stop_pend sets when STOP=1 on any RUN cycle, or when I_HLT=1 on any EXECUTE cycle.
  - At EXECUTE T3 exit, if stop_pend=1 or step_mode=1: go to IDLE with FETCH=1, EXECUTE=0, T0..T3=0, RUNNING=0, stop_pend=0, step_mode=0.
  - A STOP asserted during EXECUTE T3 itself takes effect at that same boundary.
  - The instruction always completes; there is no mid-instruction halt.
- Bus timeout:
  - If wait_cnt reaches MAX_WAIT and MEM_READY is still 0 on that cycle: next state IDLE, BUS_ERR=1 (sticky until the next START/STEP or reset), WRITE=0.
  - INSTR_COUNT does not increment on a timeout.
- WRITE flip-flop (updated every clock edge):
  - CLRWRITE=1 clears WRITE.
  - Else SETWRITE=1 sets WRITE.
  - CLRWRITE wins when both are asserted.
  - Entering IDLE forces WRITE=0. SETWRITE/CLRWRITE are ignored in IDLE.
- Reset asserted mid-instruction: all outputs return to reset values immediately (asynchronously). No instruction count is recorded.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset mid-RUN (RESET=0 while T2 in EXECUTE) -> outputs immediately FETCH=1, EXECUTE=0, T0..T3=0, RUNNING=0, WRITE=0, INSTR_COUNT=0.
2. START pulse, MEM_READY=1, STOP at cycle 20 -> T0,T1,T2,T3 FETCH then T0..T3 EXECUTE repeating. Halts after the 3rd EXECUTE T3 (cycle 24). INSTR_COUNT=3, RUNNING=0.
3. MEM_READY=0 for 3 cycles at FETCH T1 -> T1 high for 4 cycles, then T2. Instruction takes 11 cycles, BUS_ERR=0.
4. STEP pulse with I_HLT=0 -> exactly one FETCH and one EXECUTE (8 cycles), then IDLE, INSTR_COUNT+1. A second STEP repeats this. I_HLT=1 during EXECUTE T1 in free run -> IDLE after that T3.
5. MAX_WAIT=15, MEM_READY held 0 in EXECUTE T1 -> IDLE after 15 wait cycles, BUS_ERR=1, WRITE=0, count unchanged. A following START clears BUS_ERR.
6. SETWRITE at EXECUTE T1, CLRWRITE at T3 -> WRITE=1 on T2..T3. SETWRITE and CLRWRITE together -> WRITE=0. INSTR_COUNT with CNT_W=4 wraps from 15 to 0 after 16 instructions.

Source files
------------

// File: rtl/nicnac16_timing_gen.sv
// nicnac16_timing_gen: major/minor cycle sequencer for the dunc16 datapath.
// Produces FETCH/EXECUTE major levels and one-hot T0..T3 minor strobes,
// holds the memory WRITE flip-flop, and adds run/stop/single-step control,
// memory wait states on T1 and a bus-timeout trap.
// Every output comes straight from a flip-flop; the two-process FSM below
// computes all next values combinationally and one register block stores them.
module nicnac16_timing_gen #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             STEP,
    input  logic             STOP,
    input  logic             I_HLT,
    input  logic             MEM_READY,
    input  logic             SETWRITE,
    input  logic             CLRWRITE,
    output logic             FETCH,
    output logic             EXECUTE,
    output logic             T0,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic             WRITE,
    output logic             RUNNING,
    output logic             BUS_ERR,
    output logic [CNT_W-1:0] INSTR_COUNT
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One-hot minor-cycle encodings; all-zero is the idle value.
    localparam logic [3:0] MIN_NONE = 4'b0000;
    localparam logic [3:0] MIN_T0   = 4'b0001;
    localparam logic [3:0] MIN_T1   = 4'b0010;
    localparam logic [3:0] MIN_T2   = 4'b0100;
    localparam logic [3:0] MIN_T3   = 4'b1000;

    // The not-ready T1 cycle that sees this many earlier waits is the
    // MAX_WAIT-th consecutive wait and triggers the timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q,     state_n;
    logic             fetch_q,     fetch_n;
    logic             exec_q;
    logic [3:0]       minor_q,     minor_n;
    logic             write_q,     write_n;
    logic             running_q;
    logic             bus_err_q,   bus_err_n;
    logic [CNT_W-1:0] count_q,     count_n;
    logic             stop_pend_q, stop_pend_n;
    logic             step_mode_q, step_mode_n;
    logic [7:0]       wait_q,      wait_n;

    logic             halt_req;
    logic             go_idle;

    // Next-state and next-output logic for the IDLE/RUN sequencer.
    always_comb begin
        state_n     = state_q;
        fetch_n     = fetch_q;
        minor_n     = minor_q;
        write_n     = write_q;
        bus_err_n   = bus_err_q;
        count_n     = count_q;
        stop_pend_n = stop_pend_q;
        step_mode_n = step_mode_q;
        wait_n      = wait_q;
        go_idle     = 1'b0;

        // A halt request seen this cycle still counts at the current
        // boundary, so STOP during EXECUTE T3 takes effect immediately.
        halt_req = stop_pend_q | STOP | (I_HLT & ~fetch_q);

        case (state_q)
            ST_IDLE: begin
                write_n = 1'b0;
                if (START || STEP) begin
                    state_n     = ST_RUN;
                    fetch_n     = 1'b1;
                    minor_n     = MIN_T0;
                    step_mode_n = ~START;
                    stop_pend_n = 1'b0;
                    bus_err_n   = 1'b0;
                    wait_n      = 8'd0;
                end
            end

            ST_RUN: begin
                stop_pend_n = halt_req;

                // CLRWRITE has priority over SETWRITE.
                if (CLRWRITE) begin
                    write_n = 1'b0;
                end else if (SETWRITE) begin
                    write_n = 1'b1;
                end

                case (minor_q)
                    MIN_T0: begin
                        minor_n = MIN_T1;
                    end
                    MIN_T1: begin
                        if (MEM_READY) begin
                            minor_n = MIN_T2;
                            wait_n  = 8'd0;
                        end else if (wait_q >= WAIT_LAST) begin
                            go_idle   = 1'b1;
                            bus_err_n = 1'b1;
                        end else begin
                            wait_n = wait_q + 8'd1;
                        end
                    end
                    MIN_T2: begin
                        minor_n = MIN_T3;
                    end
                    MIN_T3: begin
                        if (fetch_q) begin
                            fetch_n = 1'b0;
                            minor_n = MIN_T0;
                        end else begin
                            count_n = count_q + CNT_ONE;
                            if (halt_req || step_mode_q) begin
                                go_idle = 1'b1;
                            end else begin
                                fetch_n = 1'b1;
                                minor_n = MIN_T0;
                            end
                        end
                    end
                    default: begin
                        // Corrupted minor state: recover by parking in IDLE.
                        go_idle = 1'b1;
                    end
                endcase

                if (go_idle) begin
                    state_n     = ST_IDLE;
                    fetch_n     = 1'b1;
                    minor_n     = MIN_NONE;
                    write_n     = 1'b0;
                    stop_pend_n = 1'b0;
                    step_mode_n = 1'b0;
                    wait_n      = 8'd0;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            fetch_q     <= 1'b1;
            exec_q      <= 1'b0;
            minor_q     <= MIN_NONE;
            write_q     <= 1'b0;
            running_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            step_mode_q <= 1'b0;
            wait_q      <= 8'd0;
        end else begin
            state_q     <= state_n;
            fetch_q     <= fetch_n;
            exec_q      <= ~fetch_n;
            minor_q     <= minor_n;
            write_q     <= write_n;
            running_q   <= (state_n == ST_RUN);
            bus_err_q   <= bus_err_n;
            count_q     <= count_n;
            stop_pend_q <= stop_pend_n;
            step_mode_q <= step_mode_n;
            wait_q      <= wait_n;
        end
    end

    assign FETCH       = fetch_q;
    assign EXECUTE     = exec_q;
    assign T0          = minor_q[0];
    assign T1          = minor_q[1];
    assign T2          = minor_q[2];
    assign T3          = minor_q[3];
    assign WRITE       = write_q;
    assign RUNNING     = running_q;
    assign BUS_ERR     = bus_err_q;
    assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_nicnac16_timing_gen.sv
// Directed bench for nicnac16_timing_gen. Inputs change 1 ns after a rising
// edge; outputs are observed at the same point. Cycle c of an instruction run
// is the c-th cycle after the edge that sampled START/STEP.
module tb_nicnac16_timing_gen;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;

    // Clock / reset and stimulus
    logic CLK       = 1'b0;
    logic RESET     = 1'b0;
    logic START     = 1'b0;
    logic STEP      = 1'b0;
    logic STOP      = 1'b0;
    logic I_HLT     = 1'b0;
    logic MEM_READY = 1'b1;
    logic SETWRITE  = 1'b0;
    logic CLRWRITE  = 1'b0;

    logic             FETCH, EXECUTE, T0, T1, T2, T3, WRITE, RUNNING, BUS_ERR;
    logic [CNT_W-1:0] INSTR_COUNT;

    int n_cmp = 0;
    int n_err = 0;

    logic [CNT_W-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    nicnac16_timing_gen #(
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .STEP        (STEP),
        .STOP        (STOP),
        .I_HLT       (I_HLT),
        .MEM_READY   (MEM_READY),
        .SETWRITE    (SETWRITE),
        .CLRWRITE    (CLRWRITE),
        .FETCH       (FETCH),
        .EXECUTE     (EXECUTE),
        .T0          (T0),
        .T1          (T1),
        .T2          (T2),
        .T3          (T3),
        .WRITE       (WRITE),
        .RUNNING     (RUNNING),
        .BUS_ERR     (BUS_ERR),
        .INSTR_COUNT (INSTR_COUNT)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Observed vector: {FETCH, EXECUTE, T3, T2, T1, T0, WRITE, RUNNING, BUS_ERR}
    function automatic logic [8:0] obs();
        return {FETCH, EXECUTE, T3, T2, T1, T0, WRITE, RUNNING, BUS_ERR};
    endfunction

    function automatic logic [8:0] ev(input logic f, input int ti, input logic wr,
                                      input logic run, input logic be);
        logic [3:0] t;
        t = 4'b0000;
        if (ti >= 0) t[ti] = 1'b1;
        return {f, ~f, t[3], t[2], t[1], t[0], wr, run, be};
    endfunction

    // No-wait timing: FETCH T0..T3 then EXECUTE T0..T3, repeating.
    function automatic logic [8:0] ev_plain(input int c, input logic wr, input logic be);
        return ev(((c - 1) / 4) % 2 == 0, (c - 1) % 4, wr, 1'b1, be);
    endfunction

    function automatic logic [8:0] ev_idle(input logic be);
        return ev(1'b1, -1, 1'b0, 1'b0, be);
    endfunction

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        check_eq("rst_outs", obs(), ev_idle(1'b0));
        check_eq("rst_cnt", INSTR_COUNT, 0);
        RESET = 1'b1;
        tick();
        check_eq("rst_idle_hold", obs(), ev_idle(1'b0));

        // ---------------- free run, STOP at cycle 20, STEP ignored in RUN ----------------
        START = 1'b1; tick(); START = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            check_eq($sformatf("free_c%0d", c), obs(), ev_plain(c, 1'b0, 1'b0));
            STOP = (c == 20);
            STEP = (c == 5);
            tick();
        end
        STOP = 1'b0; STEP = 1'b0;
        check_eq("free_halt", obs(), ev_idle(1'b0));
        check_eq("free_cnt", INSTR_COUNT, 3);
        tick();
        check_eq("free_idle_hold", obs(), ev_idle(1'b0));

        // ---------------- asynchronous reset during EXECUTE T2 ----------------
        START = 1'b1; tick(); START = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            SETWRITE = (c == 6);
            tick();
        end
        SETWRITE = 1'b0;
        check_eq("mid_pre", obs(), ev_plain(7, 1'b1, 1'b0));
        #1 RESET = 1'b0;
        #1;
        check_eq("mid_rst_outs", obs(), ev_idle(1'b0));
        check_eq("mid_rst_cnt", INSTR_COUNT, 0);
        tick();
        RESET = 1'b1;
        tick();

        // ---------------- wait states: 3 not-ready cycles at FETCH T1 ----------------
        START = 1'b1; tick(); START = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            logic f;
            int   ti;
            if (c == 1)      begin f = 1'b1; ti = 0; end
            else if (c <= 5) begin f = 1'b1; ti = 1; end
            else if (c == 6) begin f = 1'b1; ti = 2; end
            else if (c == 7) begin f = 1'b1; ti = 3; end
            else             begin f = 1'b0; ti = c - 8; end
            check_eq($sformatf("wait_c%0d", c), obs(), ev(f, ti, 1'b0, 1'b1, 1'b0));
            MEM_READY = !(c >= 2 && c <= 4);
            STOP      = (c == 1);
            tick();
        end
        MEM_READY = 1'b1; STOP = 1'b0;
        check_eq("wait_halt", obs(), ev_idle(1'b0));
        check_eq("wait_cnt", INSTR_COUNT, 1);

        // ---------------- single step twice ----------------
        for (int k = 0; k < 2; k++) begin
            STEP = 1'b1; tick(); STEP = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                check_eq($sformatf("step%0d_c%0d", k, c), obs(), ev_plain(c, 1'b0, 1'b0));
                tick();
            end
            check_eq($sformatf("step%0d_halt", k), obs(), ev_idle(1'b0));
            check_eq($sformatf("step%0d_cnt", k), INSTR_COUNT, 2 + k);
            tick();
            check_eq($sformatf("step%0d_hold", k), obs(), ev_idle(1'b0));
        end

        // ---------------- I_HLT: ignored in FETCH, halts from EXECUTE T1 ----------------
        START = 1'b1; tick(); START = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check_eq($sformatf("hlt_c%0d", c), obs(), ev_plain(c, 1'b0, 1'b0));
            I_HLT = (c == 2 || c == 14);
            tick();
        end
        I_HLT = 1'b0;
        check_eq("hlt_halt", obs(), ev_idle(1'b0));
        check_eq("hlt_cnt", INSTR_COUNT, 5);

        // ---------------- bus timeout in EXECUTE T1 ----------------
        START = 1'b1; tick(); START = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 5)
                check_eq($sformatf("tmo_c%0d", c), obs(), ev_plain(c, 1'b0, 1'b0));
            else
                check_eq($sformatf("tmo_c%0d", c), obs(), ev(1'b0, 1, (c >= 7), 1'b1, 1'b0));
            MEM_READY = (c < 6);
            SETWRITE  = (c == 6);
            tick();
        end
        SETWRITE = 1'b0;
        check_eq("tmo_idle", obs(), ev_idle(1'b1));
        check_eq("tmo_cnt", INSTR_COUNT, 5);
        tick();
        check_eq("tmo_sticky", obs(), ev_idle(1'b1));
        MEM_READY = 1'b1;
        START = 1'b1; tick(); START = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_eq($sformatf("tmo_clr_c%0d", c), obs(), ev_plain(c, 1'b0, 1'b0));
            STOP = (c == 1);
            tick();
        end
        STOP = 1'b0;
        check_eq("tmo_clr_halt", obs(), ev_idle(1'b0));
        check_eq("tmo_clr_cnt", INSTR_COUNT, 6);

        // ---------------- WRITE flip-flop; START+STEP together free-runs ----------------
        START = 1'b1; STEP = 1'b1; tick(); START = 1'b0; STEP = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            logic wr;
            wr = (c == 7 || c == 8 || c == 11);
            check_eq($sformatf("wr_c%0d", c), obs(), ev_plain(c, wr, 1'b0));
            SETWRITE = (c == 6 || c == 10 || c == 11);
            CLRWRITE = (c == 8 || c == 11);
            STOP     = (c == 13);
            tick();
        end
        SETWRITE = 1'b0; CLRWRITE = 1'b0; STOP = 1'b0;
        check_eq("wr_halt", obs(), ev_idle(1'b0));
        check_eq("wr_cnt", INSTR_COUNT, 8);
        SETWRITE = 1'b1; tick(); SETWRITE = 1'b0;
        check_eq("wr_idle_ignored", obs(), ev_idle(1'b0));

        // ---------------- instruction counter wraps 15 -> 0 ----------------
        for (int k = 0; k < 10; k++) exp_q.push_back(CNT_W'(8 + k));
        START = 1'b1; tick(); START = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            check_eq($sformatf("wrap_c%0d", c), obs(), ev_plain(c, 1'b0, 1'b0));
            if ((c - 1) % 8 == 0 && exp_q.size() > 0)
                check_eq($sformatf("wrap_cnt_c%0d", c), INSTR_COUNT, exp_q.pop_front());
            STOP = (c == 73);
            tick();
        end
        STOP = 1'b0;
        check_eq("wrap_halt", obs(), ev_idle(1'b0));
        check_eq("wrap_final_cnt", INSTR_COUNT, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
